// File: rtl/piano_pkg.sv
// Shared definitions for the piano key path: default sizing, event entry layout, clog2 helper.
// Optional build macro KEY_EVT_TIMESTAMP_EN appends a 16-bit timestamp field to every event entry.
package piano_pkg;

  localparam int unsigned DEFAULT_NUM_KEYS   = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned TS_W               = 16;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Key index width, never narrower than one bit.
  function automatic int unsigned key_idx_w(input int unsigned num_keys);
    return (num_keys <= 1) ? 1 : clog2(num_keys);
  endfunction

  // Event entry layout, MSB first: {key[key_w-1:0], press[, ts[TS_W-1:0]]}.
  function automatic int unsigned evt_entry_w(input int unsigned key_w);
`ifdef KEY_EVT_TIMESTAMP_EN
    return key_w + 1 + TS_W;
`else
    return key_w + 1;
`endif
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO with push/pop, full/empty, occupancy count and a registered head entry.
// Push while full is accepted only together with a pop; an entry pushed into an empty FIFO
// becomes visible at the head on the following cycle.
module key_evt_fifo
  import piano_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = DEFAULT_FIFO_DEPTH,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = ~valid_q;
  assign count   = count_q;
  assign head_data = head_q;
  assign do_pop  = pop & valid_q;
  assign do_push = push & (~full | do_pop);

  // Next pointers, storage, count and head entry (head looks through a same-cycle write).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    valid_d = (count_d != '0);
    head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Turns debounced key level changes into ordered press/release events behind a valid/ready FIFO.
// A key that toggles back while its first edge is still pending is dropped and flagged (cancel_flag).
// Optional build macro KEY_EVT_TIMESTAMP_EN adds a free-running 16-bit counter and the evt_ts output.
module key_event_encoder
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = DEFAULT_NUM_KEYS,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned KEY_W      = key_idx_w(NUM_KEYS),
  localparam int unsigned CNT_W     = clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic                evt_press,
  output logic [CNT_W-1:0]    evt_count,
`ifdef KEY_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]     evt_ts,
`endif
  output logic                cancel_flag
);

  localparam int unsigned ENTRY_W = evt_entry_w(KEY_W);

  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] ptype_q, ptype_d;
  logic                cancel_q, cancel_d;
  logic [NUM_KEYS-1:0] edge_hit;
  logic                sel_found;
  logic [KEY_W-1:0]    sel_idx;
  logic                push, pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  push_data, head_data;

  assign edge_hit = key_level ^ prev_q;
  assign pop      = evt_valid & evt_ready;
  assign push     = sel_found & (~fifo_full | pop);

  // Lowest-index pending key that is not being toggled again this cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (!sel_found && pending_q[i] && !edge_hit[i]) begin
        sel_found = 1'b1;
        sel_idx   = KEY_W'(i);
      end
    end
  end

  // Edge capture into the pending set, cancellation of re-toggled keys, and dequeue on push.
  always_comb begin
    prev_d    = key_level;
    pending_d = pending_q;
    ptype_d   = ptype_q;
    cancel_d  = cancel_q;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (edge_hit[i]) begin
        if (pending_q[i]) begin
          pending_d[i] = 1'b0;
          cancel_d     = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          ptype_d[i]   = key_level[i];
        end
      end
    end
    if (push) pending_d[sel_idx] = 1'b0;
  end

  // Edge-tracking state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      ptype_q   <= '0;
      cancel_q  <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      ptype_q   <= ptype_d;
      cancel_q  <= cancel_d;
    end
  end

`ifdef KEY_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + TS_W'(1);

  // Free-running timestamp, wraps naturally at 0xFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  // Stamp matches the counter value visible once the entry has been written.
  assign push_data = {sel_idx, ptype_q[sel_idx], ts_d};
  assign evt_ts    = head_data[TS_W-1:0];
`else
  assign push_data = {sel_idx, ptype_q[sel_idx]};
`endif

  key_evt_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (evt_count),
    .head_data (head_data)
  );

  assign evt_valid   = ~fifo_empty;
  assign evt_key     = head_data[ENTRY_W-1 -: KEY_W];
  assign evt_press   = head_data[ENTRY_W-KEY_W-1];
  assign cancel_flag = cancel_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: table of per-cycle vectors plus hand-written reset and
// timestamp sequences (the latter only when KEY_EVT_TIMESTAMP_EN is defined).
module tb_key_event_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] key_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;
  logic [2:0] evt_count;
  logic       cancel_flag;
`ifdef KEY_EVT_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  key_event_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .key_level   (key_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_press   (evt_press),
    .evt_count   (evt_count),
`ifdef KEY_EVT_TIMESTAMP_EN
    .evt_ts      (evt_ts),
`endif
    .cancel_flag (cancel_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] kl;
    logic       rdy;
    logic       ev;
    logic [2:0] ek;
    logic       ep;
    logic [2:0] ec;
    logic       cf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tcnt  = 0;

  task automatic add(input logic r, input logic [7:0] kl, input logic rdy, input logic ev,
                     input logic [2:0] ek, input logic ep, input logic [2:0] ec, input logic cf);
    vec_t v;
    v.rst = r; v.kl = kl; v.rdy = rdy; v.ev = ev; v.ek = ek; v.ep = ep; v.ec = ec; v.cf = cf;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  initial begin
    rst = 1'b1;
    key_level = 8'h00;
    evt_ready = 1'b0;
    #1;
    chk("reset valid", 32'(evt_valid), 32'd0);
    chk("reset count", 32'(evt_count), 32'd0);
    chk("reset cancel", 32'(cancel_flag), 32'd0);
    chk("reset key", 32'(evt_key), 32'd0);
    chk("reset press", 32'(evt_press), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // single press then release of key 2
    add(0, 8'h04, 1, 0, 0, 0, 0, 0);
    add(0, 8'h04, 1, 1, 2, 1, 1, 0);
    add(0, 8'h04, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 2, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    // simultaneous presses 0,3,7 serialized in ascending order
    add(0, 8'h89, 1, 0, 0, 0, 0, 0);
    add(0, 8'h89, 1, 1, 0, 1, 1, 0);
    add(0, 8'h89, 1, 1, 3, 1, 1, 0);
    add(0, 8'h89, 1, 1, 7, 1, 1, 0);
    add(0, 8'h89, 1, 0, 0, 0, 0, 0);
    // reset, then backpressure to full with keys 4,5 left pending
    add(1, 8'h89, 0, 0, 0, 0, 0, 0);
    add(0, 8'h3F, 0, 0, 0, 0, 0, 0);
    add(0, 8'h3F, 0, 1, 0, 1, 1, 0);
    add(0, 8'h3F, 0, 1, 0, 1, 2, 0);
    add(0, 8'h3F, 0, 1, 0, 1, 3, 0);
    add(0, 8'h3F, 0, 1, 0, 1, 4, 0);
    add(0, 8'h3F, 0, 1, 0, 1, 4, 0);
    // key 6 toggles up and straight back while full: cancelled
    add(0, 8'h7F, 0, 1, 0, 1, 4, 0);
    add(0, 8'h3F, 0, 1, 0, 1, 4, 1);
    // drain: 1..5 in order, no key 6
    add(0, 8'h3F, 1, 1, 1, 1, 4, 1);
    add(0, 8'h3F, 1, 1, 2, 1, 4, 1);
    add(0, 8'h3F, 1, 1, 3, 1, 3, 1);
    add(0, 8'h3F, 1, 1, 4, 1, 2, 1);
    add(0, 8'h3F, 1, 1, 5, 1, 1, 1);
    add(0, 8'h3F, 1, 0, 0, 0, 0, 1);
    add(0, 8'h3F, 1, 0, 0, 0, 0, 1);

    foreach (tbl[k]) begin
      rst       = tbl[k].rst;
      key_level = tbl[k].kl;
      evt_ready = tbl[k].rdy;
      tick();
      chk($sformatf("row%0d valid", k), 32'(evt_valid), 32'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk($sformatf("row%0d key", k), 32'(evt_key), 32'(tbl[k].ek));
        chk($sformatf("row%0d press", k), 32'(evt_press), 32'(tbl[k].ep));
      end
      chk($sformatf("row%0d count", k), 32'(evt_count), 32'(tbl[k].ec));
      chk($sformatf("row%0d cancel", k), 32'(cancel_flag), 32'(tbl[k].cf));
    end
    rst = 1'b0;

    // mid-stream reset: queue releases of keys 3,4,5, then reset between edges
    evt_ready = 1'b0;
    key_level = 8'h07;
    for (int i = 0; i < 4; i++) tick();
    chk("pre-rst valid", 32'(evt_valid), 32'd1);
    chk("pre-rst count", 32'(evt_count), 32'd3);
    chk("pre-rst key", 32'(evt_key), 32'd3);
    chk("pre-rst press", 32'(evt_press), 32'd0);
    chk("pre-rst cancel", 32'(cancel_flag), 32'd1);
    key_level = 8'h00;
    #3;
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(evt_valid), 32'd0);
    chk("async rst count", 32'(evt_count), 32'd0);
    chk("async rst cancel", 32'(cancel_flag), 32'd0);
    tick();
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post-rst idle%0d valid", i), 32'(evt_valid), 32'd0);
    end
    chk("post-rst count", 32'(evt_count), 32'd0);

`ifdef KEY_EVT_TIMESTAMP_EN
    // timestamps: counter restarts at 0 on reset release, +1 per clock
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tcnt = 0;
    while (tcnt < 100) tick();
    key_level = 8'h02;
    tick();
    tick();
    chk("ts key1 valid", 32'(evt_valid), 32'd1);
    chk("ts key1 key", 32'(evt_key), 32'd1);
    chk("ts key1 ts", 32'(evt_ts), 32'd102);
    tick();
    key_level = 8'h06;
    tick();
    tick();
    chk("ts key2 key", 32'(evt_key), 32'd2);
    chk("ts key2 ts", 32'(evt_ts), 32'd105);
    tick();
    evt_ready = 1'b0;
    while (tcnt < 32'h0000_FFFD) tick();
    key_level = 8'h1E;
    tick();
    tick();
    tick();
    chk("wrap head key", 32'(evt_key), 32'd3);
    chk("wrap head ts", 32'(evt_ts), 32'h0000_FFFF);
    tick();
    chk("wrap count", 32'(evt_count), 32'd2);
    evt_ready = 1'b1;
    tick();
    chk("wrap second key", 32'(evt_key), 32'd4);
    chk("wrap second ts", 32'(evt_ts), 32'h0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
